// File: rtl/nwr_req_gen.sv
// rtl/nwr_req_gen.sv - user write stream to SRIO NWRITE (HELLO) request generator
module nwr_req_gen #(
  parameter logic [15:0] SRC_ID        = 16'h0001,
  parameter logic [15:0] DEST_ID       = 16'h0002,
  parameter int          MAX_PKT_BYTES = 256
) (
  input  logic        log_clk,
  input  logic        log_rst,
  input  logic [33:0] user_addr_in,
  input  logic [19:0] user_tsize_in,
  input  logic [63:0] user_tdata_in,
  input  logic [7:0]  user_tkeep_in,
  input  logic        user_tfirst_in,
  input  logic        user_tvalid_in,
  input  logic        user_tlast_in,
  output logic        user_tready_o,
  output logic        nwr_ready_o,
  output logic        nwr_busy_o,
  output logic        nwr_done_o,
  output logic        err_o,
  output logic        ireq_tvalid_o,
  input  logic        ireq_tready_in,
  output logic [63:0] ireq_tdata_o,
  output logic [7:0]  ireq_tkeep_o,
  output logic        ireq_tlast_o,
  output logic [31:0] ireq_tuser_o
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t      state;
  logic [33:0] addr_q;
  logic [19:0] remaining_q;
  logic [7:0]  tid_q;
  logic [5:0]  beat_cnt_q;
  logic        err_q;

  // Current packet geometry, derived from the bytes still to send.
  logic [8:0]  pkt_bytes;
  logic [7:0]  pkt_size;
  logic [5:0]  pkt_beats;
  logic        last_pkt;
  logic        beat_hs;
  logic        xfer_final;
  logic [63:0] hdr_word;

  assign last_pkt   = (remaining_q <= 20'(MAX_PKT_BYTES));
  assign pkt_bytes  = last_pkt ? remaining_q[8:0] : 9'(MAX_PKT_BYTES);
  assign pkt_size   = 8'(pkt_bytes - 9'd1);
  assign pkt_beats  = 6'((pkt_bytes + 9'd7) >> 3);
  assign beat_hs    = (state == DATA) && user_tvalid_in && ireq_tready_in;
  assign xfer_final = (beat_cnt_q == 6'd1) && last_pkt;

  // NWRITE header: TID, FTYPE 5, TTYPE 4, prio 1, size-1, 34-bit byte address.
  assign hdr_word = {tid_q, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, pkt_size, 2'b00, addr_q};

  assign ireq_tuser_o = {SRC_ID, DEST_ID};

  // Transfer sequencing: header per packet, payload beats counted down, wrap to next packet.
  always_ff @(posedge log_clk or posedge log_rst) begin
    if (log_rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      tid_q       <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (user_tvalid_in && user_tfirst_in) begin
            addr_q      <= user_addr_in;
            remaining_q <= user_tsize_in;
            if (user_tsize_in == 20'd0) begin
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q <= 1'b0;
              state <= HDR;
            end
          end
        end
        HDR: begin
          if (ireq_tready_in) begin
            tid_q      <= tid_q + 8'd1;
            beat_cnt_q <= pkt_beats;
            state      <= DATA;
          end
        end
        DATA: begin
          if (beat_hs) begin
            beat_cnt_q <= beat_cnt_q - 6'd1;
            // user tlast must coincide exactly with the byte-count final beat
            if (user_tlast_in != xfer_final) begin
              err_q <= 1'b1;
            end
            if (beat_cnt_q == 6'd1) begin
              addr_q      <= addr_q + 34'(pkt_bytes);
              remaining_q <= remaining_q - 20'(pkt_bytes);
              state       <= last_pkt ? DONE : HDR;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output decode: header from registers, payload as zero-latency passthrough.
  always_comb begin
    ireq_tvalid_o = 1'b0;
    ireq_tdata_o  = '0;
    ireq_tkeep_o  = '0;
    ireq_tlast_o  = 1'b0;
    user_tready_o = 1'b0;
    case (state)
      HDR: begin
        ireq_tvalid_o = 1'b1;
        ireq_tdata_o  = hdr_word;
        ireq_tkeep_o  = 8'hFF;
      end
      DATA: begin
        ireq_tvalid_o = user_tvalid_in;
        ireq_tdata_o  = user_tdata_in;
        ireq_tkeep_o  = user_tkeep_in;
        ireq_tlast_o  = (beat_cnt_q == 6'd1);
        user_tready_o = ireq_tready_in;
      end
      default: begin
      end
    endcase
  end

  assign nwr_ready_o = (state == IDLE);
  assign nwr_busy_o  = (state != IDLE);
  assign nwr_done_o  = (state == DONE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_nwr_req_gen.sv
// tb/tb_nwr_req_gen.sv - scoreboard bench for nwr_req_gen
module tb_nwr_req_gen;

  localparam int MAXB = 256;

  logic        log_clk = 1'b0;
  logic        log_rst = 1'b1;
  logic [33:0] user_addr_in = '0;
  logic [19:0] user_tsize_in = '0;
  logic [63:0] user_tdata_in = '0;
  logic [7:0]  user_tkeep_in = '0;
  logic        user_tfirst_in = 1'b0;
  logic        user_tvalid_in = 1'b0;
  logic        user_tlast_in = 1'b0;
  logic        user_tready_o;
  logic        nwr_ready_o;
  logic        nwr_busy_o;
  logic        nwr_done_o;
  logic        err_o;
  logic        ireq_tvalid_o;
  logic        ireq_tready_in = 1'b1;
  logic [63:0] ireq_tdata_o;
  logic [7:0]  ireq_tkeep_o;
  logic        ireq_tlast_o;
  logic [31:0] ireq_tuser_o;

  nwr_req_gen #(.SRC_ID(16'h0001), .DEST_ID(16'h0002), .MAX_PKT_BYTES(MAXB)) dut (
    .log_clk(log_clk), .log_rst(log_rst),
    .user_addr_in(user_addr_in), .user_tsize_in(user_tsize_in),
    .user_tdata_in(user_tdata_in), .user_tkeep_in(user_tkeep_in),
    .user_tfirst_in(user_tfirst_in), .user_tvalid_in(user_tvalid_in),
    .user_tlast_in(user_tlast_in), .user_tready_o(user_tready_o),
    .nwr_ready_o(nwr_ready_o), .nwr_busy_o(nwr_busy_o), .nwr_done_o(nwr_done_o),
    .err_o(err_o), .ireq_tvalid_o(ireq_tvalid_o), .ireq_tready_in(ireq_tready_in),
    .ireq_tdata_o(ireq_tdata_o), .ireq_tkeep_o(ireq_tkeep_o),
    .ireq_tlast_o(ireq_tlast_o), .ireq_tuser_o(ireq_tuser_o)
  );

  always #5 log_clk = ~log_clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [73:0] sb [$];
  logic [7:0]  tid_m = 8'd0;
  logic        rand_rdy = 1'b0;
  logic        stall_prev = 1'b0;
  logic [72:0] prev_beat = '0;
  logic [73:0] exp_e;

  task automatic check(input string tag, input logic [72:0] got, input logic [72:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // request-side backpressure
  initial begin
    forever begin
      @(posedge log_clk);
      #1;
      ireq_tready_in = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor: pop and compare each accepted request beat
  initial begin
    forever begin
      @(negedge log_clk);
      if (log_rst) begin
        stall_prev = 1'b0;
      end else begin
        if (ireq_tvalid_o) begin
          if (stall_prev)
            check("stall_hold", {ireq_tdata_o, ireq_tkeep_o, ireq_tlast_o}, prev_beat);
          if (sb.size() > 0 && !sb[0][73])
            check("utready_follow", 73'(user_tready_o), 73'(ireq_tready_in));
          if (ireq_tready_in) begin
            check("sb_nonempty", 73'(sb.size() != 0), 73'(1));
            if (sb.size() != 0) begin
              exp_e = sb.pop_front();
              check(exp_e[73] ? "hdr_beat" : "data_beat",
                    {ireq_tdata_o, ireq_tkeep_o, ireq_tlast_o}, exp_e[72:0]);
            end
          end
        end
        stall_prev = ireq_tvalid_o && !ireq_tready_in;
        prev_beat  = {ireq_tdata_o, ireq_tkeep_o, ireq_tlast_o};
      end
    end
  end

  task automatic send(input logic [33:0] a, input int tsz, input int tl_pos,
                      input int stop_at, input logic exp_err);
    int nb, rem, pb, bi, nbk, ndrive, t;
    logic [33:0] ad;
    logic [63:0] d [$];
    logic [7:0]  k [$];
    nb = (tsz + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      d.push_back({$urandom, $urandom});
      k.push_back((i == nb - 1 && tsz % 8 != 0) ? 8'(8'hFF >> (8 - tsz % 8)) : 8'hFF);
    end
    rem = tsz; ad = a; bi = 0;
    while (rem > 0) begin
      pb = (rem > MAXB) ? MAXB : rem;
      sb.push_back({1'b1, tid_m, 4'h5, 4'h4, 1'b0, 2'b01, 1'b0, 8'(pb - 1), 2'b00, ad,
                    8'hFF, 1'b0});
      tid_m = tid_m + 8'd1;
      nbk = (pb + 7) / 8;
      for (int j = 0; j < nbk; j++) begin
        sb.push_back({1'b0, d[bi], k[bi], (j == nbk - 1)});
        bi++;
      end
      ad = ad + 34'(pb);
      rem = rem - pb;
    end
    ndrive = (stop_at >= 0) ? stop_at : nb;
    @(posedge log_clk);
    #1;
    user_addr_in  = a;
    user_tsize_in = 20'(tsz);
    if (nb == 0) begin
      user_tvalid_in = 1'b1; user_tfirst_in = 1'b1; user_tlast_in = 1'b0;
      @(posedge log_clk);
      #1;
    end else begin
      for (int i = 0; i < ndrive; i++) begin
        user_tvalid_in = 1'b1;
        user_tfirst_in = (i == 0);
        user_tlast_in  = (i == tl_pos);
        user_tdata_in  = d[i];
        user_tkeep_in  = k[i];
        t = 0;
        @(negedge log_clk);
        while (!user_tready_o && t < 300) begin
          @(negedge log_clk);
          t++;
        end
        check("beat_accept", 73'(user_tready_o), 73'(1));
        @(posedge log_clk);
        #1;
      end
    end
    user_tvalid_in = 1'b0; user_tfirst_in = 1'b0; user_tlast_in = 1'b0;
    if (stop_at < 0) begin
      t = 0;
      @(negedge log_clk);
      while (!nwr_done_o && t < 300) begin
        @(negedge log_clk);
        t++;
      end
      check("done_pulse", 73'(nwr_done_o), 73'(1));
      check("busy_in_done", 73'(nwr_busy_o), 73'(1));
      check("err", 73'(err_o), 73'(exp_err));
      @(negedge log_clk);
      check("done_one_cycle", 73'(nwr_done_o), 73'(0));
      check("ready_after", 73'(nwr_ready_o), 73'(1));
      check("sb_drained", 73'(sb.size()), 73'(0));
    end
  endtask

  task automatic check_reset_vals;
    check("rst_ready", 73'(nwr_ready_o), 73'(1));
    check("rst_busy", 73'(nwr_busy_o), 73'(0));
    check("rst_done", 73'(nwr_done_o), 73'(0));
    check("rst_err", 73'(err_o), 73'(0));
    check("rst_utready", 73'(user_tready_o), 73'(0));
    check("rst_ivalid", 73'(ireq_tvalid_o), 73'(0));
    check("rst_ibeat", {ireq_tdata_o, ireq_tkeep_o, ireq_tlast_o}, 73'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge log_clk);
    #1;
    check_reset_vals();
    check("tuser", 73'(ireq_tuser_o), 73'(32'h0001_0002));
    log_rst = 1'b0;

    send(34'h1000, 64, 7, -1, 1'b0);
    send(34'h0, 600, 74, -1, 1'b0);
    rand_rdy = 1'b1;
    send(34'h1000, 64, 7, -1, 1'b0);
    rand_rdy = 1'b0;
    send(34'h2000, 12, 1, -1, 1'b0);
    send(34'h3000, 0, -1, -1, 1'b1);
    send(34'h4000, 64, 3, -1, 1'b1);
    send(34'h1000, 64, 7, -1, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send(34'(i * 8), 8, 0, -1, 1'b0);
    end

    // abort mid-payload of a multi-packet transfer
    send(34'h0, 600, 74, 10, 1'b0);
    #2;
    log_rst = 1'b1;
    #1;
    check_reset_vals();
    sb.delete();
    tid_m = 8'd0;
    @(posedge log_clk);
    #1;
    log_rst = 1'b0;
    send(34'h1000, 64, 7, -1, 1'b0);

    repeat (4) @(posedge log_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
